// File: rtl/time_of_day_bcd.sv
// time_of_day_bcd
//   HH:MM:SS real-time counter with six BCD digit outputs for seven-segment decoders.
//   It also produces second, minute and day pulses, and accepts manual minute and
//   hour increments for setting the time.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_run          1 = prescaler and time advance; 0 = frozen
//   i_inc_min      single-cycle pulse: minutes +1 (no hour carry), clears seconds
//   i_inc_hr       single-cycle pulse: hours +1 (23 -> 00), clears seconds
//   o_sec_ones     BCD 0-9
//   o_sec_tens     BCD 0-5
//   o_min_ones     BCD 0-9
//   o_min_tens     BCD 0-5
//   o_hr_ones      BCD 0-9 (0-3 when o_hr_tens = 2)
//   o_hr_tens      BCD 0-2
//   o_sec_pulse    one cycle when seconds advance
//   o_min_pulse    one cycle when minutes advance by carry
//   o_day_pulse    one cycle on 23:59:59 -> 00:00:00
module time_of_day_bcd #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned PRE_W    = 26
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic       i_inc_min,
    input  logic       i_inc_hr,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_min_tens,
    output logic [3:0] o_hr_ones,
    output logic [3:0] o_hr_tens,
    output logic       o_sec_pulse,
    output logic       o_min_pulse,
    output logic       o_day_pulse
);

    localparam logic [PRE_W-1:0] PreMax = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] r_pre, w_pre_d;
    logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens, r_hr_ones, r_hr_tens;
    logic [3:0] w_sec_ones_d, w_sec_tens_d, w_min_ones_d, w_min_tens_d, w_hr_ones_d, w_hr_tens_d;
    logic r_sec_pulse, r_min_pulse, r_day_pulse;
    logic w_sec_pulse_d, w_min_pulse_d, w_day_pulse_d;

    logic w_tick, w_manual, w_min_at_59, w_hr_at_23;

    assign w_tick      = i_run && (r_pre == PreMax);
    assign w_manual    = i_inc_min | i_inc_hr;
    assign w_min_at_59 = (r_min_tens == 4'd5) && (r_min_ones == 4'd9);
    assign w_hr_at_23  = (r_hr_tens == 4'd2) && (r_hr_ones == 4'd3);

    always_comb begin
        w_pre_d       = r_pre;
        w_sec_ones_d  = r_sec_ones;
        w_sec_tens_d  = r_sec_tens;
        w_min_ones_d  = r_min_ones;
        w_min_tens_d  = r_min_tens;
        w_hr_ones_d   = r_hr_ones;
        w_hr_tens_d   = r_hr_tens;
        w_sec_pulse_d = 1'b0;
        w_min_pulse_d = 1'b0;
        w_day_pulse_d = 1'b0;

        // Minute/hour increment shared by the manual path and the carry chain.
        // The manual path is exclusive with the tick, so a tick arriving with a
        // button press is simply dropped.
        if (w_manual) begin
            w_pre_d      = '0;
            w_sec_ones_d = 4'd0;
            w_sec_tens_d = 4'd0;
            if (i_inc_min) begin
                if (r_min_ones == 4'd9) begin
                    w_min_ones_d = 4'd0;
                    w_min_tens_d = (r_min_tens == 4'd5) ? 4'd0 : r_min_tens + 4'd1;
                end else begin
                    w_min_ones_d = r_min_ones + 4'd1;
                end
            end
            if (i_inc_hr) begin
                if (w_hr_at_23) begin
                    w_hr_ones_d = 4'd0;
                    w_hr_tens_d = 4'd0;
                end else if (r_hr_ones == 4'd9) begin
                    w_hr_ones_d = 4'd0;
                    w_hr_tens_d = r_hr_tens + 4'd1;
                end else begin
                    w_hr_ones_d = r_hr_ones + 4'd1;
                end
            end
        end else if (i_run) begin
            if (!w_tick) begin
                w_pre_d = r_pre + PRE_W'(1);
            end else begin
                w_pre_d       = '0;
                w_sec_pulse_d = 1'b1;
                if (r_sec_ones != 4'd9) begin
                    w_sec_ones_d = r_sec_ones + 4'd1;
                end else begin
                    w_sec_ones_d = 4'd0;
                    if (r_sec_tens != 4'd5) begin
                        w_sec_tens_d = r_sec_tens + 4'd1;
                    end else begin
                        w_sec_tens_d  = 4'd0;
                        w_min_pulse_d = 1'b1;
                        if (r_min_ones != 4'd9) begin
                            w_min_ones_d = r_min_ones + 4'd1;
                        end else begin
                            w_min_ones_d = 4'd0;
                            w_min_tens_d = w_min_at_59 ? 4'd0 : r_min_tens + 4'd1;
                        end
                        if (w_min_at_59) begin
                            if (w_hr_at_23) begin
                                w_hr_ones_d   = 4'd0;
                                w_hr_tens_d   = 4'd0;
                                w_day_pulse_d = 1'b1;
                            end else if (r_hr_ones == 4'd9) begin
                                w_hr_ones_d = 4'd0;
                                w_hr_tens_d = r_hr_tens + 4'd1;
                            end else begin
                                w_hr_ones_d = r_hr_ones + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre       <= '0;
            r_sec_ones  <= 4'd0;
            r_sec_tens  <= 4'd0;
            r_min_ones  <= 4'd0;
            r_min_tens  <= 4'd0;
            r_hr_ones   <= 4'd0;
            r_hr_tens   <= 4'd0;
            r_sec_pulse <= 1'b0;
            r_min_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
        end else begin
            r_pre       <= w_pre_d;
            r_sec_ones  <= w_sec_ones_d;
            r_sec_tens  <= w_sec_tens_d;
            r_min_ones  <= w_min_ones_d;
            r_min_tens  <= w_min_tens_d;
            r_hr_ones   <= w_hr_ones_d;
            r_hr_tens   <= w_hr_tens_d;
            r_sec_pulse <= w_sec_pulse_d;
            r_min_pulse <= w_min_pulse_d;
            r_day_pulse <= w_day_pulse_d;
        end
    end

    assign o_sec_ones  = r_sec_ones;
    assign o_sec_tens  = r_sec_tens;
    assign o_min_ones  = r_min_ones;
    assign o_min_tens  = r_min_tens;
    assign o_hr_ones   = r_hr_ones;
    assign o_hr_tens   = r_hr_tens;
    assign o_sec_pulse = r_sec_pulse;
    assign o_min_pulse = r_min_pulse;
    assign o_day_pulse = r_day_pulse;

endmodule

// File: doc/time_of_day_bcd.md
Name: time_of_day_bcd

Overview:
- Real-time HH:MM:SS counter that produces six BCD digits.
- Sits directly upstream of the seven-segment decoders: each 4-bit digit output drives one decoder instance feeding one HEX display.
- Also emits second, minute and day pulses for the water-reminder scheduling logic.
- Includes manual minute/hour increment for setting the time from pre-debounced buttons.

Parameters:
- TICK_DIV, 50000000: clock cycles per second. Legal range is 2 or more; benches use 4.
- PRE_W, 26: prescaler counter width. Must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- run  input  1  1 = timekeeping advances; 0 = prescaler and time frozen.
- inc_min  input  1  single-cycle pulse; increment minutes.
- inc_hr  input  1  single-cycle pulse; increment hours.
- sec_ones  output  4  BCD 0-9.
- sec_tens  output  4  BCD 0-5.
- min_ones  output  4  BCD 0-9.
- min_tens  output  4  BCD 0-5.
- hr_ones  output  4  BCD 0-9; limited to 0-3 when hr_tens=2.
- hr_tens  output  4  BCD 0-2.
- sec_pulse  output  1  one-cycle pulse when seconds advance.
- min_pulse  output  1  one-cycle pulse when minutes advance by carry.
- day_pulse  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. Every output is a register.
- Reset:
  - All digits go to 0 (00:00:00).
  - Prescaler goes to 0.
  - sec_pulse, min_pulse and day_pulse go to 0.
  - reset overrides run, inc_min and inc_hr in the same cycle.
- Prescaler:
  - While run=1 it counts 0..TICK_DIV-1.
  - When the count is TICK_DIV-1 it wraps to 0 and raises an internal tick.
  - While run=0 the prescaler holds its value and no tick occurs.
- Tick handling (registered, 1-cycle latency): digits and pulses update on the edge after the prescaler reads TICK_DIV-1. sec_pulse=1 in that same cycle.
- Cascaded BCD carry:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 at :59 carries into min_ones and asserts min_pulse.
  - min_ones 9->0 carries into min_tens.
  - min_tens 5->0 carries into hours.
  - Hours sequence is hr_ones 9->0 with hr_tens+1, except 23 -> 00.
  - 23:59:59 -> 00:00:00 asserts day_pulse, min_pulse and sec_pulse together.
- Pulses are 0 in every cycle without the corresponding event.
- inc_min:
  - Minutes +1, wrapping 59->00.
  - No carry into hours.
  - Seconds and prescaler cleared to 0.
  - No pulses generated.
- inc_hr:
  - Hours +1, wrapping 23->00.
  - Seconds and prescaler cleared to 0.
  - Minutes unchanged.
  - No pulses generated.
- inc_min and inc_hr in the same cycle: both apply independently. Seconds and prescaler are cleared.
- Manual increment coincident with a tick: the increment wins. The tick is discarded: no seconds advance and no pulses.
- inc_min and inc_hr operate regardless of run.
- Invariant: outputs never hold a non-BCD or out-of-range value (e.g. 24, 60, sec_tens=6).
- Reset mid-count: the next run=1 cycle starts the prescaler at 0. The first tick comes exactly TICK_DIV cycles after reset deasserts.

Test Plan:
1. TICK_DIV=4; reset, then run=1 for 40 cycles -> time 00:00:10; sec_pulse seen exactly 10 times, each 4 cycles apart.
2. Drive time to 00:00:59 (59 ticks) -> next tick gives 00:01:00, with min_pulse=1 and sec_pulse=1 in the same cycle.
3. Use 23 inc_hr, 59 inc_min, then 59 ticks to reach 23:59:59 -> next tick gives 00:00:00, with day_pulse, min_pulse and sec_pulse all 1 for one cycle.
4. run=0 for 20 cycles at 00:00:05 -> digits unchanged and no pulses; run=1 -> first tick arrives after the remaining prescaler count.
5. At 00:59:30 pulse inc_min -> 00:00:00 (no hour carry, seconds cleared); at 23:xx pulse inc_hr -> 00:xx:00.
6. Assert inc_min on the same cycle a tick is due, at 00:10:20 -> 00:11:00 and sec_pulse=0. Assert reset mid-count -> 00:00:00, and the next tick occurs 4 cycles after reset drops.
